if_id_ctrl: RTL and testbench
=============================

Name: if_id_ctrl

Overview:
- Controller for the IF/ID pipeline stage feeding the combinational instruction field decoder.
- Registers the fetched instruction and its PC, and owns the valid/ready handshake with fetch.
- Detects load-use hazards against the instruction in ID, inserts exactly one bubble per hazard, and flushes on taken branches.
- Sits between the fetch unit and the decoder/ID-EX register. Also provides a saturating bubble counter for performance debug.

Parameters:
- XLEN, 32, width of instruction and PC.
- NOP, 32'h0000_0013, instruction driven on id_instruccion when ID is empty (ADDI x0,x0,0).
- CNT_W, 16, width of bubble_count.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_valid  in  1  fetch presents a valid instruction.
- if_instruccion  in  XLEN  fetched instruction.
- if_pc  in  XLEN  PC of the fetched instruction.
- if_ready  out  1  controller accepts the fetch word this cycle.
- id_instruccion  out  XLEN  registered instruction to the decoder.
- id_pc  out  XLEN  registered PC.
- id_valid  out  1  ID holds a live instruction.
- id_bubble  out  1  ID-EX must load a NOP this cycle (combinational).
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rd  in  5  destination register of the instruction in EX.
- branch_taken  in  1  EX resolved a taken branch or jump; younger instructions are dead.
- ex_stall  in  1  downstream busy; freeze IF/ID.
- bubble_count  out  CNT_W  saturating count of bubbles and flushes.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: id_instruccion=NOP, id_pc=0, id_valid=0, state=RUN, bubble_count=0. If rst is asserted mid-operation, it overrides every other input on that edge.
- FSM states: RUN, STALL, FLUSH.
- Register-use decode uses opcode = id_instruccion[6:0]:
  - uses_rs1 for 0110011, 0010011, 0000011, 0100011, 1100011, 1100111.
  - uses_rs2 for 0110011, 0100011, 1100011.
  - LUI, AUIPC and JAL use neither.
- hazard = id_valid & ex_mem_read & (ex_rd!=0) & ((uses_rs1 & id_instruccion[19:15]==ex_rd) | (uses_rs2 & id_instruccion[24:20]==ex_rd)).
- Priority per edge: rst > branch_taken > ex_stall > hazard > normal advance.
- branch_taken=1 (any state): id_valid<=0, id_instruccion<=NOP, state<=FLUSH.
  - if_ready=0 that cycle. The word on if_* is discarded.
  - bubble_count increments.
- FLUSH: lasts exactly one cycle with if_ready=0, so fetch can redirect. Then state<=RUN unless branch_taken is asserted again.
- ex_stall=1 (no branch): all registers and state hold; if_ready=0, id_bubble=0.
- RUN with hazard (no branch, no stall):
  - id_* registers hold; if_ready=0, id_bubble=1.
  - state<=STALL; bubble_count increments.
- STALL: hazard is ignored, which guarantees one bubble only.
  - if_ready=1, id_bubble=0. Advances as in normal operation.
  - state<=RUN. If ex_stall is asserted, it holds in STALL.
- Normal (RUN, no hazard): if_ready=1.
  - if_valid=1: id_instruccion<=if_instruccion, id_pc<=if_pc, id_valid<=1.
  - if_valid=0: id_valid<=0, id_instruccion<=NOP, id_pc holds.
- Combinational outputs:
  - if_ready = !rst & !branch_taken & !ex_stall & ((state==RUN & !hazard) | state==STALL).
  - id_bubble = state==RUN & hazard & !branch_taken & !ex_stall.
- Latency: one cycle from accepted fetch to id_* outputs.
- bubble_count saturates at all-ones; no wrap.
- ex_rd==0 never causes a hazard.

Test Plan:
- Reset: assert rst 2 cycles with if_valid=1 -> id_valid=0, id_instruccion=32'h00000013, bubble_count=0, if_ready=0 during rst.
- Streaming: feed 0x00500093 (pc 0x0), then 0x00A00113 (pc 0x4) on consecutive cycles with no hazards -> each appears on id_* one cycle later with id_valid=1, and if_ready stays 1.
- Load-use:
  - Stimulus: ID holds add x3,x1,x2 (0x002081B3); ex_mem_read=1, ex_rd=1.
  - Required: id_bubble=1 and if_ready=0 for exactly one cycle, with ID held; the next cycle advances; bubble_count=1.
  - Repeat with ex_rd=0 -> no bubble.
- No false hazard: ID holds lui x1,0x12345 (0x123450B7), ex_mem_read=1, ex_rd=1 -> no bubble, if_ready=1.
- Flush:
  - Stimulus: branch_taken=1 for one cycle while a valid instruction is in ID.
  - Required: the next cycle has id_valid=0 and id_instruccion=NOP; FLUSH holds if_ready=0 for one cycle; RUN resumes after; bubble_count increments by 1.
  - Also assert branch_taken together with hazard and ex_stall -> flush wins.
- Stall: hold ex_stall=1 for 3 cycles during a hazard -> id_* frozen and id_bubble=0 throughout; after release, exactly one bubble occurs.
- Saturation: set CNT_W=2 and force 5 bubbles -> bubble_count ends at 3.

Source files
------------

// File: rtl/if_id_if.sv
// if_id_if: fetch/decode/EX-feedback bundle around the IF/ID controller.
// The controller takes the slave side; fetch/EX/bench take the master side.
interface if_id_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             if_valid;
    logic [XLEN-1:0]  if_instruccion;
    logic [XLEN-1:0]  if_pc;
    logic             if_ready;
    logic [XLEN-1:0]  id_instruccion;
    logic [XLEN-1:0]  id_pc;
    logic             id_valid;
    logic             id_bubble;
    logic             ex_mem_read;
    logic [4:0]       ex_rd;
    logic             branch_taken;
    logic             ex_stall;
    logic [CNT_W-1:0] bubble_count;

    modport slave (
        input  if_valid, if_instruccion, if_pc, ex_mem_read, ex_rd, branch_taken, ex_stall,
        output if_ready, id_instruccion, id_pc, id_valid, id_bubble, bubble_count
    );

    modport master (
        output if_valid, if_instruccion, if_pc, ex_mem_read, ex_rd, branch_taken, ex_stall,
        input  if_ready, id_instruccion, id_pc, id_valid, id_bubble, bubble_count
    );
endinterface

// File: rtl/if_id_ctrl.sv
// if_id_ctrl: IF/ID pipeline register with fetch handshake, one-bubble
// load-use hazard insertion, branch flush and a saturating bubble counter.
module if_id_ctrl #(
    parameter int              XLEN  = 32,
    parameter logic [XLEN-1:0] NOP   = 32'h0000_0013,
    parameter int              CNT_W = 16
) (
    input logic     clk,
    input logic     rst,
    if_id_if.slave  bus
);
    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_e;

    state_e           state_q, state_d;
    logic [XLEN-1:0]  instr_q, instr_d, pc_q, pc_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       opcode;
    logic             uses_rs1, uses_rs2, hazard, count_en, ready, bubble;

    assign opcode = instr_q[6:0];

    always_comb begin
        uses_rs1 = opcode inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1100111};
        uses_rs2 = opcode inside {7'b0110011, 7'b0100011, 7'b1100011};
        hazard   = valid_q & bus.ex_mem_read & (bus.ex_rd != 5'd0) &
                   ((uses_rs1 & (instr_q[19:15] == bus.ex_rd)) | (uses_rs2 & (instr_q[24:20] == bus.ex_rd)));
    end

    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        pc_d     = pc_q;
        valid_d  = valid_q;
        count_en = 1'b0;
        ready    = 1'b0;
        bubble   = 1'b0;
        if (bus.branch_taken) begin
            valid_d  = 1'b0;
            instr_d  = NOP;
            state_d  = FLUSH;
            count_en = 1'b1;
        end else if (!bus.ex_stall) begin
            if (state_q == FLUSH) begin
                state_d = RUN;
            end else if (state_q == RUN && hazard) begin
                state_d  = STALL;
                count_en = 1'b1;
                bubble   = 1'b1;
            end else begin
                // STALL ignores the hazard so each load-use costs exactly one bubble
                ready   = 1'b1;
                state_d = RUN;
                valid_d = bus.if_valid;
                instr_d = bus.if_valid ? bus.if_instruccion : NOP;
                pc_d    = bus.if_valid ? bus.if_pc : pc_q;
            end
        end
        cnt_d = (count_en && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            instr_q <= NOP;
            pc_q    <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.if_ready       = ready & ~rst;
    assign bus.id_bubble      = bubble;
    assign bus.id_instruccion = instr_q;
    assign bus.id_pc          = pc_q;
    assign bus.id_valid       = valid_q;
    assign bus.bubble_count   = cnt_q;
endmodule

// File: tb/tb_if_id_ctrl.sv
// tb_if_id_ctrl: directed plus random stimulus against a rule-level model of
// the IF/ID controller; a second instance with a 2-bit counter covers saturation.
module tb_if_id_ctrl;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] ADD = 32'h0020_81B3;
    localparam logic [31:0] LUI = 32'h1234_50B7;

    logic        clk = 1'b0;
    logic        rst, if_valid, ex_mem_read, branch_taken, ex_stall;
    logic [31:0] if_instruccion, if_pc;
    logic [4:0]  ex_rd;

    int vectors = 0, miscompares = 0;

    logic        m_known = 1'b0, m_valid, m_flush, m_stall;
    logic [31:0] m_instr, m_pc;
    int          m_cnt;

    if_id_if #(.XLEN(32), .CNT_W(16)) b1 ();
    if_id_if #(.XLEN(32), .CNT_W(2))  b2 ();

    assign b1.if_valid = if_valid;           assign b2.if_valid = if_valid;
    assign b1.if_instruccion = if_instruccion; assign b2.if_instruccion = if_instruccion;
    assign b1.if_pc = if_pc;                 assign b2.if_pc = if_pc;
    assign b1.ex_mem_read = ex_mem_read;     assign b2.ex_mem_read = ex_mem_read;
    assign b1.ex_rd = ex_rd;                 assign b2.ex_rd = ex_rd;
    assign b1.branch_taken = branch_taken;   assign b2.branch_taken = branch_taken;
    assign b1.ex_stall = ex_stall;           assign b2.ex_stall = ex_stall;

    if_id_ctrl #(.XLEN(32), .NOP(NOP), .CNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(b1));
    if_id_ctrl #(.XLEN(32), .NOP(NOP), .CNT_W(2))  dut2 (.clk(clk), .rst(rst), .bus(b2));

    always #5 clk = ~clk;

    function automatic logic reads_rs1(input logic [31:0] i);
        case (i[6:0])
            7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic reads_rs2(input logic [31:0] i);
        case (i[6:0])
            7'h33, 7'h23, 7'h63: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive, check outputs mid-cycle, then advance the model past the edge.
    task automatic step(input logic r, input logic v, input logic [31:0] ins, input logic [31:0] p,
                        input logic mr, input logic [4:0] rd, input logic bt, input logic st);
        logic hz, er, eb;
        rst = r; if_valid = v; if_instruccion = ins; if_pc = p;
        ex_mem_read = mr; ex_rd = rd; branch_taken = bt; ex_stall = st;
        hz = m_valid && mr && rd != 5'd0 &&
             ((reads_rs1(m_instr) && m_instr[19:15] == rd) || (reads_rs2(m_instr) && m_instr[24:20] == rd));
        er = !r && !bt && !st && (m_stall || (!m_flush && !hz));
        eb = !m_flush && !m_stall && hz && !bt && !st;
        @(negedge clk);
        chk("if_ready", {63'd0, b1.if_ready}, {63'd0, er});
        if (m_known) begin
            chk("id_bubble", {63'd0, b1.id_bubble}, {63'd0, eb});
            chk("id_valid", {63'd0, b1.id_valid}, {63'd0, m_valid});
            chk("id_instr", {32'd0, b1.id_instruccion}, {32'd0, m_instr});
            chk("id_pc", {32'd0, b1.id_pc}, {32'd0, m_pc});
            chk("bubble_count", {48'd0, b1.bubble_count}, 64'(m_cnt > 65535 ? 65535 : m_cnt));
            chk("bubble_count_sat2", {62'd0, b2.bubble_count}, 64'(m_cnt > 3 ? 3 : m_cnt));
        end
        @(posedge clk);
        #1;
        if (r) begin
            m_known = 1'b1; m_valid = 1'b0; m_instr = NOP; m_pc = '0;
            m_flush = 1'b0; m_stall = 1'b0; m_cnt = 0;
        end else if (!m_known) begin
        end else if (bt) begin
            m_valid = 1'b0; m_instr = NOP; m_flush = 1'b1; m_stall = 1'b0; m_cnt++;
        end else if (st) begin
        end else if (m_flush) begin
            m_flush = 1'b0;
        end else if (eb) begin
            m_stall = 1'b1; m_cnt++;
        end else begin
            m_stall = 1'b0;
            m_valid = v;
            m_instr = v ? ins : NOP;
            if (v) m_pc = p;
        end
    endtask

    initial begin
        logic [31:0] ri;
        logic [6:0]  ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67, 7'h37, 7'h17, 7'h6F};
        step(1, 1, 32'hDEAD_BEEF, 32'h100, 0, 0, 0, 0);
        step(1, 1, 32'hDEAD_BEEF, 32'h104, 0, 0, 0, 0);
        chk("reset_instr_nop", {32'd0, b1.id_instruccion}, {32'd0, NOP});
        // streaming
        step(0, 1, 32'h0050_0093, 32'h0, 0, 0, 0, 0);
        step(0, 1, 32'h00A0_0113, 32'h4, 0, 0, 0, 0);
        chk("stream_second", {32'd0, b1.id_instruccion}, 64'h00A0_0113);
        // load-use on rs1 = x1, then stall-state advance
        step(0, 1, ADD, 32'h8, 0, 0, 0, 0);
        step(0, 1, NOP, 32'hC, 1, 1, 0, 0);
        step(0, 1, NOP, 32'hC, 1, 1, 0, 0);
        step(0, 0, NOP, 32'h0, 0, 0, 0, 0);
        // ex_rd = 0 never stalls
        step(0, 1, ADD, 32'h10, 0, 0, 0, 0);
        step(0, 1, NOP, 32'h14, 1, 0, 0, 0);
        // lui reads no registers
        step(0, 1, LUI, 32'h18, 0, 0, 0, 0);
        step(0, 1, NOP, 32'h1C, 1, 1, 0, 0);
        // plain flush
        step(0, 1, ADD, 32'h20, 0, 0, 0, 0);
        step(0, 1, NOP, 32'h24, 0, 0, 1, 0);
        step(0, 1, NOP, 32'h28, 0, 0, 0, 0);
        step(0, 1, NOP, 32'h2C, 0, 0, 0, 0);
        // flush beats hazard and stall
        step(0, 1, ADD, 32'h30, 0, 0, 0, 0);
        step(0, 1, NOP, 32'h34, 1, 1, 1, 1);
        step(0, 1, NOP, 32'h38, 0, 0, 0, 0);
        // stall held during hazard, then one bubble
        step(0, 1, ADD, 32'h40, 0, 0, 0, 0);
        repeat (3) step(0, 1, NOP, 32'h44, 1, 2, 0, 1);
        step(0, 1, NOP, 32'h44, 1, 2, 0, 0);
        step(0, 1, NOP, 32'h44, 1, 2, 0, 0);
        step(0, 1, NOP, 32'h48, 0, 0, 0, 0);
        // random traffic
        for (int n = 0; n < 800; n++) begin
            ri = $urandom;
            ri[6:0]   = ops[$urandom_range(0, 8)];
            ri[19:15] = 5'($urandom_range(0, 3));
            ri[24:20] = 5'($urandom_range(0, 3));
            step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, ri, $urandom,
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
